// File: rtl/mul_ctrl.sv
// Sequencing controller for the shared RV32M multiplier: latches operands, holds the
// pipeline for LATENCY cycles, returns the selected word. `MUL_CTRL_FUSE_EN adds a product cache.
module mul_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_en_o,
    output logic [2:0]  mul_func3_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic [31:0] mul_lo_i,
    input  logic [31:0] mul_hi_i,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       hit;

    function automatic logic [31:0] select_word(input logic [2:0] f, input logic [63:0] p);
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    assign accept  = req_i && !func3_i[2] && !flush_i && (state == IDLE);
    assign capture = (state == CALC) && (cnt == 4'd0) && !flush_i;

`ifdef MUL_CTRL_FUSE_EN
    logic [31:0] c_op1, c_op2;
    logic [1:0]  c_cls;
    logic [63:0] c_prod;
    logic        c_vld;

    // Signedness class: 2'b11 signed*signed, 2'b10 signed*unsigned, 2'b00 unsigned*unsigned.
    function automatic logic [1:0] sign_class(input logic [2:0] f);
        case (f[1:0])
            2'b01:   return 2'b11;
            2'b10:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // MUL hits under any class because the low word does not depend on signedness.
    assign hit = c_vld && (c_op1 == op1_i) && (c_op2 == op2_i) &&
                 ((func3_i[1:0] == 2'b00) || (c_cls == sign_class(func3_i)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld  <= 1'b0;
            c_op1  <= '0;
            c_op2  <= '0;
            c_cls  <= '0;
            c_prod <= '0;
        end else if (capture) begin
            c_vld  <= 1'b1;
            c_op1  <= mul_op1_o;
            c_op2  <= mul_op2_o;
            c_cls  <= sign_class(mul_func3_o);
            c_prod <= {mul_hi_i, mul_lo_i};
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_o    = 1'b1;
                    state_next = hit ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt == 4'd0) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mul_en_o       = (state == CALC);
    assign result_valid_o = (state == DONE) && !flush_i;
    assign rd_we_o        = result_valid_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            mul_op1_o   <= '0;
            mul_op2_o   <= '0;
            mul_func3_o <= '0;
            rd_addr_o   <= '0;
            result_o    <= '0;
        end else begin
            if (accept) begin
                mul_op1_o   <= op1_i;
                mul_op2_o   <= op2_i;
                mul_func3_o <= func3_i;
                rd_addr_o   <= rd_addr_i;
                cnt         <= CNT_INIT;
`ifdef MUL_CTRL_FUSE_EN
                if (hit) result_o <= select_word(func3_i, c_prod);
`endif
            end else if ((state == CALC) && !flush_i && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) result_o <= select_word(mul_func3_o, {mul_hi_i, mul_lo_i});
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: vector table plus flush, reset and cache sequences,
// with a datapath model that only drives a valid product after LATENCY stable cycles.
module tb_mul_ctrl;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  func3_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        stall_o, mul_en_o;
    logic [2:0]  mul_func3_o;
    logic [31:0] mul_op1_o, mul_op2_o;
    logic [31:0] mul_lo_i, mul_hi_i;
    logic        result_valid_o, rd_we_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int total = 0;
    int pass  = 0;

    mul_ctrl #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .func3_i(func3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .stall_o(stall_o), .mul_en_o(mul_en_o), .mul_func3_o(mul_func3_o),
        .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
        .mul_lo_i(mul_lo_i), .mul_hi_i(mul_hi_i),
        .result_valid_o(result_valid_o), .result_o(result_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o)
    );

    always #5 clk = ~clk;

    // Datapath model: product of the presented operands, garbage until inputs held long enough.
    logic [63:0] ea, eb, prod;
    int held;
    always_comb begin
        ea = (mul_func3_o[1:0] == 2'b01 || mul_func3_o[1:0] == 2'b10) ?
             {{32{mul_op1_o[31]}}, mul_op1_o} : {32'b0, mul_op1_o};
        eb = (mul_func3_o[1:0] == 2'b01) ? {{32{mul_op2_o[31]}}, mul_op2_o} : {32'b0, mul_op2_o};
        prod = ea * eb;
    end
    always_ff @(posedge clk) held <= mul_en_o ? held + 1 : 0;
    assign mul_lo_i = (mul_en_o && held >= LATENCY - 1) ? prod[31:0]  : 32'hDEADBEEF;
    assign mul_hi_i = (mul_en_o && held >= LATENCY - 1) ? prod[63:32] : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Starts one cycle after a posedge with the controller idle; returns the same way.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        req_i = 1'b1; func3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd;
        #1 chk({nm, "_stall_T"}, 32'(stall_o), 32'd1);
        while (lat < 40) begin
            @(posedge clk); #1;
            req_i = 1'b0; op1_i = '0; op2_i = '0;
            lat++;
            if (lat == 1) begin
                chk({nm, "_en_T1"}, 32'(mul_en_o), (exp_lat > 1) ? 32'd1 : 32'd0);
                chk({nm, "_op1_T1"}, mul_op1_o, a);
                chk({nm, "_op2_T1"}, mul_op2_o, b);
            end
            if (result_valid_o) break;
            chk({nm, "_stall_calc"}, 32'(stall_o), 32'd1);
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_result"}, result_o, exp);
        chk({nm, "_rd"}, 32'(rd_addr_o), 32'(rd));
        chk({nm, "_we"}, 32'(rd_we_o), 32'd1);
        chk({nm, "_stall_done"}, 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, 32'(result_valid_o), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk_all_zero(input string nm);
        chk({nm, "_stall"}, 32'(stall_o), 32'd0);
        chk({nm, "_en"}, 32'(mul_en_o), 32'd0);
        chk({nm, "_op1"}, mul_op1_o, 32'd0);
        chk({nm, "_op2"}, mul_op2_o, 32'd0);
        chk({nm, "_f3"}, 32'(mul_func3_o), 32'd0);
        chk({nm, "_res"}, result_o, 32'd0);
        chk({nm, "_rd"}, 32'(rd_addr_o), 32'd0);
        chk({nm, "_vld"}, 32'(result_valid_o), 32'd0);
        chk({nm, "_we"}, 32'(rd_we_o), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{"mul_neg",    3'b000, 32'h00000007, 32'hFFFFFFFE, 5'd5,  32'hFFFFFFF2};
        vecs[1] = '{"mulh",       3'b001, 32'hFFFFFFFE, 32'h00000003, 5'd6,  32'hFFFFFFFF};
        vecs[2] = '{"mulhu",      3'b011, 32'hFFFFFFFE, 32'h00000003, 5'd7,  32'h00000002};
        vecs[3] = '{"mulhsu",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF};
        vecs[4] = '{"mul_shift",  3'b000, 32'h12345678, 32'h00000010, 5'd31, 32'h23456780};
        vecs[5] = '{"mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE};
        vecs[6] = '{"mulh_pos",   3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd9,  32'h3FFFFFFF};

        rst = 1'b0; req_i = 1'b0; func3_i = '0; op1_i = '0; op2_i = '0;
        rd_addr_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, LATENCY + 1);

        // func3[2]=1 is not an M-multiply: ignored
        req_i = 1'b1; func3_i = 3'b100; op1_i = 32'd2; op2_i = 32'd2;
        #1 chk("div_ignored_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        req_i = 1'b0; func3_i = 3'b000;
        chk("div_ignored_en", 32'(mul_en_o), 32'd0);

        // flush in IDLE blocks acceptance
        req_i = 1'b1; flush_i = 1'b1; op1_i = 32'd4; op2_i = 32'd4;
        #1 chk("flush_idle_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        req_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_en", 32'(mul_en_o), 32'd0);

        // flush at T+1 of a MUL
        req_i = 1'b1; func3_i = 3'b000; op1_i = 32'd9; op2_i = 32'd9; rd_addr_i = 5'd3;
        #1 chk("flush_calc_stall_T", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        req_i = 1'b0;
        chk("flush_calc_en_T1", 32'(mul_en_o), 32'd1);
        flush_i = 1'b1;
        #1 chk("flush_calc_stall_T1", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_calc_en_T2", 32'(mul_en_o), 32'd0);
        chk("flush_calc_stall_T2", 32'(stall_o), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (result_valid_o) seen++;
            @(posedge clk); #1;
        end
        chk("flush_calc_no_valid", 32'(seen), 32'd0);

        // reset asserted during CALC
        req_i = 1'b1; func3_i = 3'b000; op1_i = 32'd5; op2_i = 32'd6; rd_addr_i = 5'd10;
        @(posedge clk); #1;
        req_i = 1'b0;
        chk("rst_mid_en_before", 32'(mul_en_o), 32'd1);
        rst = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 3'b000, 32'd3, 32'd4, 5'd12, 32'h0000000C, LATENCY + 1);

        // Same-operand MULH then MUL: the MUL hits the cache when it is built in
        run_op("fuse_mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd14, 32'h40000000, LATENCY + 1);
`ifdef MUL_CTRL_FUSE_EN
        run_op("fuse_mul", 3'b000, 32'h80000000, 32'h80000000, 5'd15, 32'h00000000, 1);
`else
        run_op("fuse_mul", 3'b000, 32'h80000000, 32'h80000000, 5'd15, 32'h00000000, LATENCY + 1);
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller between the execute stage and the shared 32x32 multiplier datapath for RV32M MUL/MULH/MULHSU/MULHU.
- Accepts one request at a time and latches the operands so the datapath inputs stay stable.
- Treats the multiplier as a LATENCY-cycle multicycle path and stalls the pipeline while it computes.
- Returns the selected 32-bit result with its rd address and write-enable; honours pipeline flushes.

Parameters:
- LATENCY, 2, cycles the datapath inputs are held stable before the product is captured; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req_i  input  1  execute stage presents an M-extension instruction
- func3_i  input  3  instruction func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; bit2=1 is not handled)
- op1_i  input  32  rs1 value
- op2_i  input  32  rs2 value
- rd_addr_i  input  5  destination register
- flush_i  input  1  pipeline flush (branch/jump taken)
- stall_o  output  1  hold the PC and IF/ID/EX registers
- mul_en_o  output  1  datapath enable
- mul_func3_o  output  3  func3 to the datapath
- mul_op1_o  output  32  latched operand 1
- mul_op2_o  output  32  latched operand 2
- mul_lo_i  input  32  product bits [31:0] from the datapath
- mul_hi_i  input  32  product bits [63:32] from the datapath
- result_valid_o  output  1  result valid, single-cycle pulse
- result_o  output  32  selected result
- rd_addr_o  output  5  destination of the result
- rd_we_o  output  1  register-file write enable (equal to result_valid_o)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter cleared.
  - All registered outputs are 0: mul_en_o, mul_op1_o, mul_op2_o, mul_func3_o, result_o, rd_addr_o, result_valid_o, rd_we_o.
  - The cache, when present, is invalidated.
- Accept condition: req_i=1, func3_i[2]=0, flush_i=0, state=IDLE.
  - With func3_i[2]=1, req_i is ignored: no stall, no state change.
- FSM has three states: IDLE, CALC, DONE.
- IDLE, on accept at cycle T:
  - Latch op1, op2, func3, rd.
  - Next state CALC; counter=LATENCY-1.
- CALC:
  - mul_en_o=1; the mul_op*/mul_func3 outputs stay constant.
  - Counter decrements each cycle.
  - When counter=0: capture mul_lo_i/mul_hi_i; go to DONE.
  - CALC lasts exactly LATENCY cycles (T+1 .. T+LATENCY).
- DONE, at cycle T+LATENCY+1:
  - result_valid_o=1 and rd_we_o=1.
  - result_o is the low word for MUL, otherwise the high word.
  - mul_en_o=0.
  - Next state is always IDLE. No new accept is possible in DONE; the next instruction arrives at EX after the pipeline advances.
- stall_o is combinational:
  - 1 when (IDLE and accept condition) or state=CALC.
  - 0 in DONE.
  - The pipeline therefore advances on the DONE cycle, together with the writeback.
- Flush:
  - flush_i=1 in CALC or DONE: next state IDLE, no result_valid_o pulse, stall_o drops the same cycle.
  - flush_i=1 in IDLE blocks acceptance.
  - Flush has priority over every other event.
- Reset mid-operation aborts immediately; no result is produced.
- Datapath contract: the product is sampled only after LATENCY cycles of stable inputs. The datapath sees mul_en_o=1 only in CALC.

Optional Feature:
- Macro: MUL_CTRL_FUSE_EN.
- Defined: product cache.
  - Contents: last op1, op2, signedness class (MULH=ss, MULHSU=su, MULHU/MUL=uu), full 64-bit product, valid bit.
  - Hit for MULH/MULHSU/MULHU: operands and class match.
  - Hit for MUL: operands match under any class, since the low word is class-independent.
  - On a hit at accept (cycle T): skip CALC and go IDLE->DONE; stall_o=1 only at T; result valid at T+1.
  - The cache is updated at each CALC capture.
  - A flush during CALC leaves the previous cache contents intact.
- Undefined: no cache; every request takes the full CALC sequence.

Test Plan:
- LATENCY=2, MUL op1=0x00000007 op2=0xFFFFFFFE, rd=5:
  - stall_o high T..T+2.
  - result_valid_o at T+3 with result_o=0xFFFFFFF2, rd_addr_o=5.
- MULH 0xFFFFFFFE * 0x00000003 -> result_o=0xFFFFFFFF.
- MULHU with the same operands -> result_o=0x00000002.
- MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> result_o=0xFFFFFFFF.
- flush_i pulse at T+1 of a MUL -> no result_valid_o; state IDLE at T+2; stall_o low at T+1.
- rst deasserted-low at T+1 during CALC -> all outputs 0 immediately; a later MUL 3*4 returns 0x0000000C at the normal latency.
- MUL_CTRL_FUSE_EN: MULH 0x80000000*0x80000000 (result 0x40000000), then MUL on the same operands:
  - Second request gives valid at T+1 with result_o=0x00000000.
  - Second request never asserts mul_en_o.
